// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Main control FSM of the multicycle RV32I core. Every instruction is
//   sequenced one state per clock through fetch, decode, execute, memory
//   and writeback. The datapath has one shared ALU and one memory port.
//   All outputs are combinational decodes of the current state, the IR
//   fields, the ALU flags and mem_ready. No output is registered.
//
//   Optional feature macro: MULTI_BRANCH_EN
//     defined   - beq/bne/blt/bge/bltu/bgeu are legal. Branch funct3 010
//                 and 011 halt the core.
//     undefined - only beq is legal. Every other branch funct3 halts.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   synchronous active-high; next state is FETCH
//   instruction   in   IR contents; uses [6:0], [14:12] and [30]
//   N, Z, C, V    in   ALU flags of the current cycle's operation
//   mem_ready     in   memory completes the current access this cycle
//   PC_wren       out  PC register load
//   IR_wren       out  IR / old-PC register load
//   addr_sel      out  memory address: 0 = PC, 1 = result
//   mem_wren      out  memory write strobe
//   regfile_wren  out  register file write enable
//   ALU_asel      out  00 PC, 01 oldPC, 10 src1
//   ALU_bsel      out  00 src2, 01 ximm, 10 constant 4
//   result_sel    out  00 ALU_out reg, 01 data reg, 10 ALU_result
//   ximm_sel      out  00 I, 01 S, 10 B, 11 J
//   ALU_control   out  ALU operation code
//   jalr_mask     out  clear bit 0 of the PC-path result
//   halted        out  FSM is in HALT
module multicycle_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        N,
    input  logic        Z,
    input  logic        C,
    input  logic        V,
    input  logic        mem_ready,
    output logic        PC_wren,
    output logic        IR_wren,
    output logic        addr_sel,
    output logic        mem_wren,
    output logic        regfile_wren,
    output logic [1:0]  ALU_asel,
    output logic [1:0]  ALU_bsel,
    output logic [1:0]  result_sel,
    output logic [1:0]  ximm_sel,
    output logic [3:0]  ALU_control,
    output logic        jalr_mask,
    output logic        halted
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_JALR_ADR,
        S_JALR, S_HALT
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    state_t      r_state;
    state_t      w_next;
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic        w_bit30;
    logic        w_branch_legal;
    logic        w_taken;
    logic        w_pc_wren;
    logic        w_ir_wren;
    logic        w_mem_wren;
    logic        w_rf_wren;
    logic        w_unused_bits;

    assign w_opcode      = instruction[6:0];
    assign w_funct3      = instruction[14:12];
    assign w_bit30       = instruction[30];
    assign w_unused_bits = ^{instruction[31], instruction[29:15], instruction[11:7]};

    // funct3 -> ALU op. bit30 selects SUB only for R-type, SRA for both.
    function automatic logic [3:0] f_alu_op(input logic [2:0] f3,
                                            input logic       is_r,
                                            input logic       b30);
        logic [3:0] op;
        case (f3)
            3'b000:  op = (is_r && b30) ? ALU_SUB : ALU_ADD;
            3'b001:  op = 4'b0110;
            3'b010:  op = 4'b0101;
            3'b011:  op = 4'b1001;
            3'b100:  op = 4'b0100;
            3'b101:  op = b30 ? 4'b1000 : 4'b0111;
            3'b110:  op = 4'b0011;
            default: op = 4'b0010;
        endcase
        return op;
    endfunction

`ifdef MULTI_BRANCH_EN
    assign w_branch_legal = (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
`else
    assign w_branch_legal = (w_funct3 == 3'b000);
`endif

    // Flags come from src1 - src2 computed in BRANCH. C means no borrow.
    always_comb begin
        w_taken = 1'b0;
        case (w_funct3)
            3'b000:  w_taken = Z;
            3'b001:  w_taken = ~Z;
            3'b100:  w_taken = N ^ V;
            3'b101:  w_taken = ~(N ^ V);
            3'b110:  w_taken = ~C;
            3'b111:  w_taken = C;
            default: w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_pc_wren   = 1'b0;
        w_ir_wren   = 1'b0;
        w_mem_wren  = 1'b0;
        w_rf_wren   = 1'b0;
        addr_sel    = 1'b0;
        ALU_asel    = 2'b00;
        ALU_bsel    = 2'b00;
        result_sel  = 2'b00;
        ximm_sel    = 2'b00;
        ALU_control = ALU_ADD;
        jalr_mask   = 1'b0;
        halted      = 1'b0;
        case (r_state)
            S_FETCH: begin
                ALU_bsel   = 2'b10;
                result_sel = 2'b10;
                if (mem_ready) begin
                    w_ir_wren = 1'b1;
                    w_pc_wren = 1'b1;
                    w_next    = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed here into ALU_out.
                ALU_asel = 2'b01;
                ALU_bsel = 2'b01;
                ximm_sel = (w_opcode == OP_BRANCH) ? 2'b10 : 2'b11;
                case (w_opcode)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_R:              w_next = S_EXEC_R;
                    OP_I:              w_next = S_EXEC_I;
                    OP_BRANCH:         w_next = w_branch_legal ? S_BRANCH : S_HALT;
                    OP_JAL:            w_next = S_JAL;
                    OP_JALR:           w_next = S_JALR_ADR;
                    default:           w_next = S_HALT;
                endcase
            end
            S_MEMADR: begin
                ALU_asel = 2'b10;
                ALU_bsel = 2'b01;
                if (w_opcode == OP_STORE) begin
                    ximm_sel = 2'b01;
                    w_next   = S_MEMWRITE;
                end else begin
                    w_next   = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                addr_sel = 1'b1;
                if (mem_ready) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_sel = 2'b01;
                w_rf_wren  = 1'b1;
                w_next     = S_FETCH;
            end
            S_MEMWRITE: begin
                addr_sel   = 1'b1;
                w_mem_wren = 1'b1;
                if (mem_ready) w_next = S_FETCH;
            end
            S_EXEC_R: begin
                ALU_asel    = 2'b10;
                ALU_control = f_alu_op(w_funct3, 1'b1, w_bit30);
                w_next      = S_ALUWB;
            end
            S_EXEC_I: begin
                ALU_asel    = 2'b10;
                ALU_bsel    = 2'b01;
                ALU_control = f_alu_op(w_funct3, 1'b0, w_bit30);
                w_next      = S_ALUWB;
            end
            S_ALUWB: begin
                w_rf_wren = 1'b1;
                w_next    = S_FETCH;
            end
            S_BRANCH: begin
                ALU_asel    = 2'b10;
                ALU_control = ALU_SUB;
                w_pc_wren   = w_taken;
                w_next      = S_FETCH;
            end
            S_JAL: begin
                ALU_asel  = 2'b01;
                ALU_bsel  = 2'b10;
                w_pc_wren = 1'b1;
                w_next    = S_ALUWB;
            end
            S_JALR_ADR: begin
                ALU_asel = 2'b10;
                ALU_bsel = 2'b01;
                w_next   = S_JALR;
            end
            S_JALR: begin
                ALU_asel  = 2'b01;
                ALU_bsel  = 2'b10;
                jalr_mask = 1'b1;
                w_pc_wren = 1'b1;
                w_next    = S_ALUWB;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Reset suppresses every architectural write in the cycle it is seen.
    assign PC_wren      = w_pc_wren  & ~reset;
    assign IR_wren      = w_ir_wren  & ~reset;
    assign mem_wren     = w_mem_wren & ~reset;
    assign regfile_wren = w_rf_wren  & ~reset;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        N, Z, C, V;
    logic        mem_ready;
    logic        PC_wren, IR_wren, addr_sel, mem_wren, regfile_wren;
    logic [1:0]  ALU_asel, ALU_bsel, result_sel, ximm_sel;
    logic [3:0]  ALU_control;
    logic        jalr_mask, halted;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .instruction(instruction),
        .N(N), .Z(Z), .C(C), .V(V), .mem_ready(mem_ready),
        .PC_wren(PC_wren), .IR_wren(IR_wren), .addr_sel(addr_sel),
        .mem_wren(mem_wren), .regfile_wren(regfile_wren),
        .ALU_asel(ALU_asel), .ALU_bsel(ALU_bsel), .result_sel(result_sel),
        .ximm_sel(ximm_sel), .ALU_control(ALU_control),
        .jalr_mask(jalr_mask), .halted(halted)
    );

    typedef struct packed {
        logic       pc, ir, as, mw, rw;
        logic [1:0] a, b, r, x;
        logic [3:0] alu;
        logic       jm, h;
    } outv_t;

    typedef struct packed {
        logic  mr;
        outv_t o;
    } step_t;

    step_t plan[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    outv_t got;

    assign got = {PC_wren, IR_wren, addr_sel, mem_wren, regfile_wren,
                  ALU_asel, ALU_bsel, result_sel, ximm_sel, ALU_control,
                  jalr_mask, halted};

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // ALU operation named by the instruction semantics.
    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic is_r, input logic b30);
        case (f3)
            3'd0: return (is_r && b30) ? 4'd1 : 4'd0;
            3'd1: return 4'd6;
            3'd2: return 4'd5;
            3'd3: return 4'd9;
            3'd4: return 4'd4;
            3'd5: return b30 ? 4'd8 : 4'd7;
            3'd6: return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    function automatic logic br_legal(input logic [2:0] f3);
`ifdef MULTI_BRANCH_EN
        return (f3 != 3'd2) && (f3 != 3'd3);
`else
        return (f3 == 3'd0);
`endif
    endfunction

    task automatic push(input logic mr, input outv_t o);
        plan.push_back(step_t'{mr, o});
    endtask

    // Expected per-cycle output trace for one instruction.
    task automatic build(input logic [31:0] ins, input int sf, input int sm,
                         input int nh, input logic taken);
        outv_t o;
        logic [6:0] op;
        logic [2:0] f3;
        op = ins[6:0];
        f3 = ins[14:12];
        plan.delete();
        o = '0; o.b = 2'b10; o.r = 2'b10;
        repeat (sf) push(1'b0, o);
        o.pc = 1'b1; o.ir = 1'b1;
        push(1'b1, o);
        o = '0; o.a = 2'b01; o.b = 2'b01; o.x = (op == 7'b1100011) ? 2'b10 : 2'b11;
        push(rbit(), o);
        case (op)
            7'b0000011: begin
                o = '0; o.a = 2'b10; o.b = 2'b01; o.x = 2'b00; push(rbit(), o);
                o = '0; o.as = 1'b1;
                repeat (sm) push(1'b0, o);
                push(1'b1, o);
                o = '0; o.r = 2'b01; o.rw = 1'b1; push(rbit(), o);
            end
            7'b0100011: begin
                o = '0; o.a = 2'b10; o.b = 2'b01; o.x = 2'b01; push(rbit(), o);
                o = '0; o.as = 1'b1; o.mw = 1'b1;
                repeat (sm) push(1'b0, o);
                push(1'b1, o);
            end
            7'b0110011: begin
                o = '0; o.a = 2'b10; o.alu = alu_of(f3, 1'b1, ins[30]); push(rbit(), o);
                o = '0; o.rw = 1'b1; push(rbit(), o);
            end
            7'b0010011: begin
                o = '0; o.a = 2'b10; o.b = 2'b01; o.alu = alu_of(f3, 1'b0, ins[30]); push(rbit(), o);
                o = '0; o.rw = 1'b1; push(rbit(), o);
            end
            7'b1100011: begin
                if (br_legal(f3)) begin
                    o = '0; o.a = 2'b10; o.alu = 4'd1; o.pc = taken; push(rbit(), o);
                end else begin
                    o = '0; o.h = 1'b1;
                    repeat (nh) push(rbit(), o);
                end
            end
            7'b1101111: begin
                o = '0; o.a = 2'b01; o.b = 2'b10; o.pc = 1'b1; push(rbit(), o);
                o = '0; o.rw = 1'b1; push(rbit(), o);
            end
            7'b1100111: begin
                o = '0; o.a = 2'b10; o.b = 2'b01; push(rbit(), o);
                o = '0; o.a = 2'b01; o.b = 2'b10; o.pc = 1'b1; o.jm = 1'b1; push(rbit(), o);
                o = '0; o.rw = 1'b1; push(rbit(), o);
            end
            default: begin
                o = '0; o.h = 1'b1;
                repeat (nh) push(rbit(), o);
            end
        endcase
    endtask

    // Called just after a rising edge; checks each cycle mid-period.
    task automatic run_plan(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            mem_ready = plan[i].mr;
            @(negedge clk);
            n_cmp++;
            assert (got === plan[i].o) else begin
                n_bad++;
                $error("FAIL %s step%0d got=%h exp=%h", tag, i, got, plan[i].o);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rst_cycle(input string tag, input logic mr);
        reset = 1'b1;
        mem_ready = mr;
        @(negedge clk);
        n_cmp++;
        assert ({PC_wren, IR_wren, mem_wren, regfile_wren} === 4'b0000) else begin
            n_bad++;
            $error("FAIL %s enables got=%b exp=0000", tag, {PC_wren, IR_wren, mem_wren, regfile_wren});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Flags and taken outcome derived from real operand comparison.
    task automatic make_flags(input logic [2:0] f3, output logic taken);
        logic [31:0] a, b, res;
        logic        cout;
        a = $urandom;
        b = ($urandom_range(0, 3) == 0) ? a : $urandom;
        {cout, res} = {1'b0, a} + {1'b0, ~b} + 33'd1;
        N = res[31];
        Z = (res == 32'd0);
        C = cout;
        V = (a[31] != b[31]) && (res[31] != a[31]);
        case (f3)
            3'd0: taken = (a == b);
            3'd1: taken = (a != b);
            3'd4: taken = ($signed(a) < $signed(b));
            3'd5: taken = ($signed(a) >= $signed(b));
            3'd6: taken = (a < b);
            3'd7: taken = (a >= b);
            default: taken = 1'b0;
        endcase
    endtask

    initial begin
        logic [31:0] ins;
        logic        tk;
        logic [6:0]  op;
        reset = 1'b1;
        mem_ready = 1'b0;
        instruction = 32'd0;
        {N, Z, C, V} = 4'b0000;
        @(posedge clk);
        #1;
        rst_cycle("reset", 1'b1);

        // add x3,x1,x2
        instruction = 32'h002081B3;
        build(instruction, 0, 0, 0, 1'b0);
        run_plan("add", plan.size());

        // lw with 2 fetch stalls and 3 read stalls
        instruction = 32'h0000A183;
        build(instruction, 2, 3, 0, 1'b0);
        run_plan("lw_stall", plan.size());

        // beq taken / not taken
        instruction = 32'h00208463;
        {N, Z, C, V} = 4'b0110;
        build(instruction, 0, 0, 0, 1'b1);
        run_plan("beq_taken", plan.size());
        {N, Z, C, V} = 4'b0010;
        build(instruction, 0, 0, 0, 1'b0);
        run_plan("beq_not", plan.size());

`ifdef MULTI_BRANCH_EN
        {N, Z, C, V} = 4'b0000;
        instruction = 32'h0020E463;
        build(instruction, 0, 0, 0, 1'b1);
        run_plan("bltu_c0", plan.size());
        instruction = 32'h0020F463;
        build(instruction, 0, 0, 0, 1'b0);
        run_plan("bgeu_c0", plan.size());
`else
        instruction = 32'h00209463;
        build(instruction, 0, 0, 2, 1'b0);
        run_plan("bne_halt", plan.size());
        rst_cycle("bne_halt_rst", 1'b1);
`endif

        // jalr
        instruction = 32'h000080E7;
        build(instruction, 0, 0, 0, 1'b0);
        run_plan("jalr", plan.size());

        // illegal opcode: halted for 20 cycles
        instruction = 32'h0000007F;
        build(instruction, 0, 0, 20, 1'b0);
        run_plan("halt7f", plan.size());
        rst_cycle("halt_rst", 1'b1);

        // reset landing in the MEMWRITE completion cycle
        instruction = 32'h0020A023;
        build(instruction, 0, 1, 0, 1'b0);
        run_plan("sw_pre_rst", plan.size() - 1);
        rst_cycle("rst_memwrite", 1'b1);

        // randomized instruction stream
        for (int k = 0; k < 200; k++) begin
            ins = $urandom;
            case ($urandom_range(0, 15))
                0, 1:    op = 7'b0000011;
                2, 3:    op = 7'b0100011;
                4, 5:    op = 7'b0110011;
                6, 7:    op = 7'b0010011;
                8, 9, 10: op = 7'b1100011;
                11, 12:  op = 7'b1101111;
                13, 14:  op = 7'b1100111;
                default: begin
                    op = 7'($urandom);
                    while (op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
                           op == 7'b0010011 || op == 7'b1100011 || op == 7'b1101111 ||
                           op == 7'b1100111)
                        op = 7'($urandom);
                end
            endcase
            ins[6:0] = op;
            make_flags(ins[14:12], tk);
            instruction = ins;
            build(ins, $urandom_range(0, 3), $urandom_range(0, 3), 3, tk);
            run_plan("rand", plan.size());
            if (plan[plan.size() - 1].o.h)
                rst_cycle("rand_rst", rbit());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control FSM for the multicycle variant of the RV32I core. It sequences a shared-ALU, single-memory-port datapath: fetch, decode, execute, memory and writeback. Each instruction runs as a series of states, one state per clock. It decodes `instruction` (the IR output) and the N/Z/C/V flags, and drives every datapath select and write enable. Memory wait states are absorbed through a `mem_ready` handshake.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high; state returns to FETCH on the next edge
- `instruction`  in  32  IR contents; decoder uses [6:0], [14:12] and bit 30
- `N`,`Z`,`C`,`V`  in  1 each  flags from the ALU for the current cycle's operation
- `mem_ready`  in  1  memory completes the current access this cycle
- `PC_wren`  out  1  PC register load
- `IR_wren`  out  1  IR and old-PC register load
- `addr_sel`  out  1  memory address: 0 = PC, 1 = result
- `mem_wren`  out  1  memory write strobe
- `regfile_wren`  out  1  regfile write port 3 enable
- `ALU_asel`  out  2  00 = PC, 01 = oldPC, 10 = src1
- `ALU_bsel`  out  2  00 = src2, 01 = ximm, 10 = constant 4
- `result_sel`  out  2  00 = ALU_out reg, 01 = data reg, 10 = ALU_result
- `ximm_sel`  out  2  00 = I, 01 = S, 10 = B, 11 = J
- `ALU_control`  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLL, 0111 SRL, 1000 SRA, 1001 SLTU
- `jalr_mask`  out  1  clear bit 0 of result on the PC path
- `halted`  out  1  FSM is in HALT

## Operation
States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, JALR_ADR, JALR, HALT.

State actions and transitions:
- **FETCH**: `addr_sel`=0; ALU computes PC+4 (asel 00, bsel 10, ADD, result_sel 10).
  - Holds while `mem_ready`=0.
  - When `mem_ready`=1: `IR_wren`=`PC_wren`=1, then go to DECODE.
- **DECODE**: ALU computes oldPC+ximm (asel 01, bsel 01, ximm_sel B for branch opcodes, J for all others). Branches to a state by opcode:
  - 0000011 → MEMADR
  - 0100011 → MEMADR
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR_ADR
  - any other opcode → HALT
- **MEMADR**: src1+ximm (I for loads, S for stores).
  - Load → MEMREAD; store → MEMWRITE.
- **MEMREAD**: `addr_sel`=1, result_sel 00.
  - Holds until `mem_ready`, then → MEMWB.
- **MEMWB**: result_sel 01, `regfile_wren`=1, then → FETCH.
- **MEMWRITE**: `addr_sel`=1, `mem_wren`=1 every cycle in the state.
  - Exits to FETCH on the `mem_ready` cycle.
- **EXEC_R / EXEC_I**: ALU operands are src1 with src2 (R) or src1 with ximm I (I).
  - `ALU_control` from funct3: 000 ADD (SUB if R and bit30), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA if bit30), 110 OR, 111 AND.
  - Next state → ALUWB.
- **ALUWB**: result_sel 00, `regfile_wren`=1, then → FETCH.
- **BRANCH**: src1 − src2 (SUB). result_sel 00 selects the DECODE-computed target.
  - `PC_wren` equals the taken condition; it is combinational on the flags.
  - Taken conditions: beq Z; bne !Z; blt N^V; bge !(N^V); bltu !C; bgeu C.
  - Next state → FETCH.
- **JAL**: result_sel 00, `PC_wren`=1; ALU computes oldPC+4. Next state → ALUWB.
- **JALR_ADR**: src1+ximm I. Next state → JALR.
- **JALR**: result_sel 00, `jalr_mask`=1, `PC_wren`=1; ALU computes oldPC+4. Next state → ALUWB.
- **HALT**: all enables 0, `halted`=1. Leaves only on reset.

Output rules:
- Outputs not listed for a state are 0 (ADD for `ALU_control`).
- All outputs are decoded from the state plus `instruction`, flags and `mem_ready`; there are no output registers.

## Timing
- Cycle counts with `mem_ready` tied to 1:
  - lw 5
  - sw 4
  - R-type and I-type 4
  - branch 3
  - jal 4
  - jalr 5
- Each extra `mem_ready`=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- The memory handshake completes on the cycle where the state is a memory state and `mem_ready`=1. No request signal is needed.
- Reset:
  - While `reset` is high, `PC_wren`, `IR_wren`, `mem_wren` and `regfile_wren` are forced to 0.
  - The first cycle after reset deasserts is FETCH with `halted`=0.
- Reset asserted mid-instruction (including in MEMWRITE or HALT) aborts the instruction. No write occurs in that cycle.
- The decode inputs (`instruction`, flags) are sampled only in the state that uses them. IR changes only in the FETCH handshake cycle.

## Configuration
- `MULTI_BRANCH_EN` defined: all six branch funct3 codes are legal. funct3 010 and 011 → HALT from DECODE.
- Undefined: only beq (funct3 000) is legal. Any other branch funct3 → HALT from DECODE.

## Test plan
- Reset, then `add x3,x1,x2` with `mem_ready`=1 → states FETCH, DECODE, EXEC_R, ALUWB. `ALU_control`=0000; `regfile_wren`=1 only in cycle 4.
- `lw` with `mem_ready` low 2 cycles in FETCH and 3 in MEMREAD → 10 cycles total. `IR_wren` pulses once; `regfile_wren` pulses once, in MEMWB.
- `beq` with Z=1 → `PC_wren`=1 in BRANCH. With Z=0 → `PC_wren`=0. Total 3 cycles each.
- With `MULTI_BRANCH_EN`: bltu with C=0 is taken and bgeu with C=0 is not. Without the macro, bne → `halted`=1 in the 3rd cycle.
- `jalr` → 5 cycles. `jalr_mask`=1 and `PC_wren`=1 only in JALR; `regfile_wren` in ALUWB.
- Opcode 0x7F → HALT with all enables 0 for 20 cycles. Reset during MEMWRITE → `mem_wren`=0 that cycle, then FETCH.
